// File: rtl/spi_slave_pkg.sv
// Shared FSM state type, command encodings and command/state legality helper
// for the SPI slave front end.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic cmd_ok(input state_e st, input logic [1:0] cmd);
    logic ok;
    ok = 1'b1;
    case (st)
      WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  ok = (cmd == CMD_RD_ADDR);
      READ_DATA: ok = (cmd == CMD_RD_DATA);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serialiser: latches one read word on start and shifts it out MSB-first,
// one bit per clock, returning MISO to its idle level afterwards.
module spi_tx_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_miso,
  output logic              o_busy,
  output logic              o_done
);
  localparam int unsigned      TXC_W    = $clog2(DATA_W + 1);
  localparam logic [TXC_W-1:0] TXC_LAST = TXC_W'(DATA_W);

  logic [DATA_W-1:0] r_sr;
  logic [TXC_W-1:0]  r_cnt;
  logic              r_active;
  logic              r_miso;

  // r_cnt counts bits already placed on MISO; it holds at DATA_W until aborted.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_miso   <= MISO_IDLE;
    end else if (r_active) begin
      if (r_cnt == TXC_LAST) begin
        r_miso   <= MISO_IDLE;
        r_active <= 1'b0;
      end else begin
        r_miso <= r_sr[DATA_W-1];
        r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
        r_cnt  <= r_cnt + TXC_W'(1);
      end
    end else if (i_start) begin
      r_miso   <= i_tx_data[DATA_W-1];
      r_sr     <= {i_tx_data[DATA_W-2:0], 1'b0};
      r_cnt    <= TXC_W'(1);
      r_active <= 1'b1;
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_active;
  assign o_done = r_active && (r_cnt == TXC_LAST);

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front end: deserialises {cmd, payload} frames, tracks read address/data
// ordering and hands RAM read data to the MISO serialiser. Define SPI_SLAVE_ERR_EN for frame_err.
module spi_slave_param #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic              frame_err
`endif
);
  import spi_slave_pkg::*;

  localparam int unsigned     FRAME_W = DATA_W + 2;
  localparam int unsigned     BC_W    = $clog2(FRAME_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W);

  state_e             r_cs, w_ns;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_addr_seen;
  logic               r_tx_arm;
  logic               w_sample, w_last, w_deliver;
  logic               w_tx_start, w_tx_busy, w_tx_done;

  assign w_sample    = !ss_n && (r_cs != IDLE) && (r_bit_cnt != BC_LAST);
  assign w_last      = w_sample && (r_bit_cnt == BC_W'(FRAME_W - 1));
  assign w_shift_nxt = {r_shift, MOSI};
  assign w_tx_start  = r_tx_arm && tx_valid && !ss_n;

`ifdef SPI_SLAVE_ERR_EN
  logic r_mis, r_frame_err, w_mis, w_abort;

  // At the second cmd bit r_shift[0] still holds cmd[1].
  assign w_mis     = w_sample && (r_bit_cnt == BC_W'(1)) && !cmd_ok(r_cs, {r_shift[0], MOSI});
  assign w_abort   = ss_n && (r_bit_cnt != '0) && (r_bit_cnt != BC_LAST);
  assign w_deliver = w_last && !r_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_mis || w_abort;
      if (ss_n)       r_mis <= 1'b0;
      else if (w_mis) r_mis <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign w_deliver = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_cs <= IDLE;
    else     r_cs <= w_ns;
  end

  always_comb begin
    w_ns = r_cs;
    if (ss_n) begin
      w_ns = IDLE;
    end else begin
      unique case (r_cs)
        IDLE:    w_ns = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)            w_ns = WRITE;
          else if (r_addr_seen) w_ns = READ_DATA;
          else                  w_ns = READ_ADD;
        end
        default: w_ns = r_cs;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_addr_seen <= 1'b0;
      r_tx_arm    <= 1'b0;
    end else begin
      r_rx_valid <= w_deliver;
      if (ss_n)          r_bit_cnt <= '0;
      else if (w_sample) r_bit_cnt <= r_bit_cnt + BC_W'(1);
      if (w_sample)  r_shift   <= w_shift_nxt[FRAME_W-2:0];
      if (w_deliver) r_rx_data <= w_shift_nxt;
      // A completed or aborted MISO shift consumes the pending read address.
      if (w_tx_done || (ss_n && w_tx_busy))           r_addr_seen <= 1'b0;
      else if (r_rx_valid && (r_cs == READ_ADD))      r_addr_seen <= 1'b1;
      if (ss_n || w_tx_start)                         r_tx_arm <= 1'b0;
      else if (w_deliver && (r_cs == READ_DATA))      r_tx_arm <= 1'b1;
    end
  end

  spi_tx_serializer #(
    .DATA_W    (DATA_W),
    .MISO_IDLE (MISO_IDLE)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_tx_start),
    .i_abort   (ss_n),
    .i_tx_data (tx_data),
    .o_miso    (MISO),
    .o_busy    (w_tx_busy),
    .o_done    (w_tx_done)
  );

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised self-checking bench for spi_slave_param (8-bit and 16-bit instances);
// honours SPI_SLAVE_ERR_EN when defined.
module tb_spi_slave_param;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = DW + 2;
  localparam logic        MI = 1'b0;

`ifdef SPI_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
  logic frame_err, frame_err16;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, ss_n, mosi, miso, rx_valid, tx_valid;
  logic [FW-1:0] rx_data;
  logic [DW-1:0] tx_data;
  logic          ss_n16, mosi16, miso16, rx_valid16, tx_valid16;
  logic [17:0]   rx_data16;
  logic [15:0]   tx_data16;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          m_addr_seen = 1'b0;
  bit          m_rd_data   = 1'b0;
  int unsigned m_sent      = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(DW), .MISO_IDLE(MI)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_SLAVE_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  spi_slave_param #(.DATA_W(16), .MISO_IDLE(1'b1)) dut16 (
    .clk(clk), .rst(rst), .ss_n(ss_n16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid16)
`ifdef SPI_SLAVE_ERR_EN
    , .frame_err(frame_err16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nb bits of frame f in a fresh ss_n window; leaves ss_n low.
  task automatic send(input logic [FW-1:0] f, input int unsigned nb);
    bit rd, mis, dlv;
    rd  = f[FW-1];
    mis = rd && (nb >= 2) && (f[FW-2] != m_addr_seen);
    dlv = (nb == FW) && !(mis && ERR_EN);
    ss_n = 1'b0; mosi = 1'($urandom);
    @(negedge clk);
    check("rxv_idle", 32'(rx_valid), 32'(0));
    for (int unsigned i = 0; i < nb; i++) begin
      mosi = f[FW-1-i];
      @(negedge clk);
      check("rxv_frame", 32'(rx_valid), 32'(dlv && (i == FW - 1)));
`ifdef SPI_SLAVE_ERR_EN
      check("ferr_mis", 32'(frame_err), 32'(mis && (i == 1)));
`endif
    end
    if (dlv) check("rx_data", 32'(rx_data), 32'(f));
    m_rd_data = dlv && rd && m_addr_seen;
    if (dlv && rd && !m_addr_seen) m_addr_seen = 1'b1;
    m_sent = nb;
  endtask

  task automatic tail(input int unsigned n);
    repeat (n) begin
      mosi = 1'($urandom);
      @(negedge clk);
      check("rxv_tail", 32'(rx_valid), 32'(0));
`ifdef SPI_SLAVE_ERR_EN
      check("ferr_tail", 32'(frame_err), 32'(0));
`endif
    end
  endtask

  task automatic end_window();
    bit ab;
    ab = (m_sent >= 1) && (m_sent < FW);
    ss_n = 1'b1; mosi = 1'($urandom);
    @(negedge clk);
    check("miso_end", 32'(miso), 32'(MI));
`ifdef SPI_SLAVE_ERR_EN
    check("ferr_abort", 32'(frame_err), 32'(ab));
`endif
    @(negedge clk);
    check("rxv_end", 32'(rx_valid), 32'(0));
    m_sent = 0;
  endtask

  // No read data pending: tx_valid must not start a shift.
  task automatic tx_probe();
    tx_data = '1; tx_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("miso_noarm", 32'(miso), 32'(MI));
    end
    tx_valid = 1'b0;
  endtask

  task automatic read_data(input logic [DW-1:0] d, input int unsigned w, input int unsigned nbits);
    tx_valid = 1'b0;
    repeat (w) begin
      tx_data = DW'($urandom);
      @(negedge clk);
      check("miso_wait", 32'(miso), 32'(MI));
    end
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k < nbits; k++) begin
      check("miso_bit", 32'(miso), 32'(d[DW-1-k]));
      tx_valid = 1'($urandom);
      tx_data  = DW'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (nbits == DW) check("miso_done", 32'(miso), 32'(MI));
    else             check("miso_bit", 32'(miso), 32'(d[DW-1-nbits]));
    m_addr_seen = 1'b0;
  endtask

  task automatic send16(input logic [17:0] f);
    ss_n16 = 1'b0; mosi16 = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 18; i++) begin
      mosi16 = f[17-i];
      @(negedge clk);
      check("rxv16", 32'(rx_valid16), 32'(i == 17));
    end
    check("rx_data16", 32'(rx_data16), 32'(f));
    @(negedge clk);
    check("rxv16_tail", 32'(rx_valid16), 32'(0));
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [15:0]   d16;
    int unsigned   kind, nb;

    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss_n16 = 1'b1; mosi16 = 1'b0; tx_valid16 = 1'b0; tx_data16 = '0;
    repeat (3) @(negedge clk);
    check("rst_rxv", 32'(rx_valid), 32'(0));
    check("rst_rxd", 32'(rx_data), 32'(0));
    check("rst_miso", 32'(miso), 32'(MI));
    check("rst_miso16", 32'(miso16), 32'(1));
`ifdef SPI_SLAVE_ERR_EN
    check("rst_ferr", 32'(frame_err), 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // Write address frame
    send(10'b00_1010_0101, FW); tail(3); tx_probe(); end_window();

    // Read address then read data, 0xC3 on MISO
    send(10'b10_0000_0011, FW); tail(2); tx_probe(); end_window();
    f = FW'($urandom); f[FW-1:FW-2] = 2'b11;
    send(f, FW); tail(2);
    check("rd_pending", 32'(m_rd_data), 32'(1));
    read_data(8'hC3, 2, DW); end_window();

    // Write frame aborted after 5 bits
    send(10'b01_1100_1010, 5); end_window();

    // Reset while MISO is shifting 0xFF
    send(10'b10_0101_0101, FW); tail(1); end_window();
    send(10'b11_0101_1010, FW); tail(1);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    check("miso_pre_rst", 32'(miso), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ss_n = 1'b1;
    check("rst_mid_miso", 32'(miso), 32'(MI));
    check("rst_mid_rxv", 32'(rx_valid), 32'(0));
    m_addr_seen = 1'b0; m_sent = 0;
    @(negedge clk);

    // Read-data command while no address is pending
    send(10'b11_0110_1001, FW); tail(2); tx_probe(); end_window();

    repeat (40) begin
      kind = $urandom_range(0, 3);
      f = FW'($urandom);
      case (kind)
        0:       f[FW-1] = 1'b0;
        1:       f[FW-1:FW-2] = {1'b1, 1'(m_addr_seen)};
        2:       f[FW-1] = 1'b1;
        default: f = f;
      endcase
      nb = (kind == 3) ? $urandom_range(1, FW - 1) : FW;
      send(f, nb);
      if (nb == FW) begin
        tail(2);
        if (m_rd_data)
          read_data(DW'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : DW);
        else
          tx_probe();
      end
      end_window();
    end

    // 16-bit payload instance, MISO idles high
    send16({2'b00, 16'($urandom)});
    ss_n16 = 1'b1; @(negedge clk); @(negedge clk);
    send16({2'b10, 16'($urandom)});
    ss_n16 = 1'b1; @(negedge clk); @(negedge clk);
    send16({2'b11, 16'($urandom)});
    d16 = 16'hA55A; tx_data16 = d16; tx_valid16 = 1'b1;
    @(negedge clk);
    tx_valid16 = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      check("miso16_bit", 32'(miso16), 32'(d16[15-k]));
      @(negedge clk);
    end
    check("miso16_idle", 32'(miso16), 32'(1));
    ss_n16 = 1'b1; @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
